// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the interrupt controller: register map, FSM
// state encodings, the idle level marker and the vector arithmetic.
package irq_ctrl_pkg;

  localparam logic [1:0] IRQ_REG_MASK  = 2'd0;
  localparam logic [1:0] IRQ_REG_PEND  = 2'd1;
  localparam logic [1:0] IRQ_REG_INSVC = 2'd2;
  localparam logic [1:0] IRQ_REG_STAT  = 2'd3;

  // Level reported in STAT when no handler is running.
  localparam logic [2:0] IRQ_LVL_NONE = 3'd7;

  typedef enum logic [1:0] {
    IRQ_ST_IDLE   = 2'd0,
    IRQ_ST_TAKE   = 2'd1,
    IRQ_ST_SETTLE = 2'd2
  } irq_state_e;

  // Vector for a source index; the sum wraps at 16 bits.
  function automatic logic [15:0] vec_calc(input logic [15:0] base,
                                           input logic [15:0] stride,
                                           input logic [2:0]  idx);
    return base + 16'(idx) * stride;
  endfunction

endpackage

// File: rtl/irq_ctrl_if.sv
// Signal bundle between the interrupt controller, the core's interrupt
// port, the peripheral request lines and the register bus. Source and
// data lanes are sized for the maximum of eight sources.
interface irq_ctrl_if;

  logic [7:0]  i_src;
  logic        i_int_en;
  logic        i_iret;
  logic        o_irq_take;
  logic [15:0] o_irq_vector;
  logic        i_wr;
  logic [1:0]  i_addr;
  logic [7:0]  i_wdata;
  logic [7:0]  o_rdata;

  // Core / bus side.
  modport master (
    output i_src, i_int_en, i_iret, i_wr, i_addr, i_wdata,
    input  o_irq_take, o_irq_vector, o_rdata
  );

  // Controller side.
  modport slave (
    input  i_src, i_int_en, i_iret, i_wr, i_addr, i_wdata,
    output o_irq_take, o_irq_vector, o_rdata
  );

endinterface

// File: rtl/irq_ctrl_prio_enc.sv
// Lowest-index-wins priority encoder: {valid, idx} of the first set bit.
module irq_prio_enc #(
  parameter int N_SRC = 8
) (
  input  logic [N_SRC-1:0] req,
  output logic             valid,
  output logic [2:0]       idx
);

  // Scan from the top so the lowest set index is the last one written.
  always_comb begin
    // NOTE: outputs get defaults before the loop so no path leaves them unassigned (no latch).
    valid = 1'b0;
    idx   = 3'd0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        idx   = 3'(i);
      end
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: latches source requests, applies mask and fixed
// priority, and tracks an in-service stack mirroring the core's depth.
// Build option: define IRQ_CTRL_NEST_EN to allow nesting up to MAX_DEPTH;
// otherwise only one handler may be in service at a time.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int          N_SRC      = 8,
  parameter int          MAX_DEPTH  = 2,
  parameter logic [15:0] VEC_BASE   = 16'h0020,
  parameter logic [15:0] VEC_STRIDE = 16'h0004
) (
  input  logic       i_clk,
  input  logic       i_rst,
  irq_ctrl_if.slave  bus
);

`ifdef IRQ_CTRL_NEST_EN
  localparam logic [1:0] DEPTH_LIM = 2'(MAX_DEPTH);
`else
  // Always 1 for any legal MAX_DEPTH: a single handler at a time.
  localparam logic [1:0] DEPTH_LIM = 2'(MAX_DEPTH > 0);
`endif

  localparam logic [N_SRC-1:0] ONE = N_SRC'(1);

  irq_state_e       state_q, state_d;
  logic [N_SRC-1:0] mask_q, pend_q, pend_d, insvc_q, insvc_d;
  logic [2:0]       stack_q [4];
  logic [1:0]       depth_q;
  logic [15:0]      vec_q;

  logic [N_SRC-1:0] ready;
  logic             cand_valid;
  logic [2:0]       cand_idx;
  logic [1:0]       top_ptr;
  logic [2:0]       top_lvl;
  logic             push, pop;
  logic [N_SRC-1:0] push_oh, pop_oh;

  assign ready = pend_q & mask_q & ~insvc_q;

  irq_prio_enc #(.N_SRC(N_SRC)) u_prio_enc (
    .req   (ready),
    .valid (cand_valid),
    .idx   (cand_idx)
  );

  assign top_ptr = depth_q - 2'd1;
  assign top_lvl = (depth_q == 2'd0) ? IRQ_LVL_NONE : stack_q[top_ptr];

  // An empty stack is checked explicitly: source 7 must not compare against the idle marker.
  assign push = cand_valid && bus.i_int_en && (depth_q < DEPTH_LIM) &&
                ((depth_q == 2'd0) || (cand_idx < top_lvl)) &&
                (state_q == IRQ_ST_IDLE) && !bus.i_iret;
  assign pop  = bus.i_iret && (depth_q != 2'd0);

  assign push_oh = ONE << cand_idx;
  assign pop_oh  = ONE << top_lvl;

  // FSM state register.
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses <= so every register samples pre-edge values.
    if (!i_rst) state_q <= IRQ_ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state: one-cycle take pulse followed by one settle cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IRQ_ST_IDLE:   if (push) state_d = IRQ_ST_TAKE;
      IRQ_ST_TAKE:   state_d = IRQ_ST_SETTLE;
      IRQ_ST_SETTLE: state_d = IRQ_ST_IDLE;
      default:       state_d = IRQ_ST_IDLE;
    endcase
  end

  // Pending next value: W1C and the take clear first, new requests win.
  always_comb begin
    pend_d = pend_q;
    if (bus.i_wr && bus.i_addr == IRQ_REG_PEND) pend_d = pend_d & ~bus.i_wdata[N_SRC-1:0];
    if (push) pend_d = pend_d & ~push_oh;
    pend_d = pend_d | bus.i_src[N_SRC-1:0];
  end

  // Mask and pending registers.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      mask_q <= '0;
      pend_q <= '0;
    end else begin
      if (bus.i_wr && bus.i_addr == IRQ_REG_MASK) mask_q <= bus.i_wdata[N_SRC-1:0];
      pend_q <= pend_d;
    end
  end

  // In-service bits next value: retire the stack top, then mark a new take.
  always_comb begin
    insvc_d = insvc_q;
    if (pop)  insvc_d = insvc_d & ~pop_oh;
    if (push) insvc_d = insvc_d | push_oh;
  end

  // In-service stack, depth counter and vector register.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      // NOTE: the stack is tiny and its contents feed STAT, so it is reset rather than left undefined.
      for (int i = 0; i < 4; i++) stack_q[i] <= '0;
      depth_q <= 2'd0;
      insvc_q <= '0;
      vec_q   <= VEC_BASE;
    end else begin
      insvc_q <= insvc_d;
      if (push) begin
        stack_q[depth_q] <= cand_idx;
        depth_q          <= depth_q + 2'd1;
        vec_q            <= vec_calc(VEC_BASE, VEC_STRIDE, cand_idx);
      end else if (pop) begin
        depth_q <= depth_q - 2'd1;
      end
    end
  end

  // Register read mux.
  always_comb begin
    bus.o_rdata = 8'h00;
    case (bus.i_addr)
      IRQ_REG_MASK:  bus.o_rdata = 8'(mask_q);
      IRQ_REG_PEND:  bus.o_rdata = 8'(pend_q);
      IRQ_REG_INSVC: bus.o_rdata = 8'(insvc_q);
      IRQ_REG_STAT:  bus.o_rdata = {3'b000, depth_q, top_lvl};
      default:       bus.o_rdata = 8'h00;
    endcase
  end

  assign bus.o_irq_take   = (state_q == IRQ_ST_TAKE);
  assign bus.o_irq_vector = vec_q;

endmodule
